// File: rtl/counter_mode_monitor_pkg.sv
// Shared encodings for count-bus monitors: FSM states, step classes and the
// counting-mode bit shared with the mode counter itself.
package counter_mode_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    STEP_UP     = 3'd0,
    STEP_DOWN   = 3'd1,
    STEP_HOLD   = 3'd2,
    STEP_RESYNC = 3'd3,
    STEP_JUMP   = 3'd4
  } step_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/counter_mode_monitor_step_classifier.sv
// Combinational classification of one observed count step relative to the
// previous sample; reusable by any count-bus checker.
module count_step_classifier
  import counter_mode_monitor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  output step_t            step
);

  logic [WIDTH-1:0] delta;

  assign delta = count_in - prev;

  // Ordering matters: a wrap to zero must classify as UP, not RESYNC.
  always_comb begin
    step = STEP_JUMP;
    if (delta == WIDTH'(1))       step = STEP_UP;
    else if (delta == '1)         step = STEP_DOWN;
    else if (delta == '0)         step = STEP_HOLD;
    else if (count_in == '0)      step = STEP_RESYNC;
    else                          step = STEP_JUMP;
  end

endmodule

// File: rtl/counter_mode_monitor.sv
// Observes an up/down counter's count bus, infers its direction and reports
// lock, reversals, resyncs and illegal jumps with a saturating error tally.
module counter_mode_monitor
  import counter_mode_monitor_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 3,
  parameter int ERRW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             mode_out,
  output logic             dir_change,
  output logic             resync,
  output logic             err,
  output logic [ERRW-1:0]  err_count
);

  localparam logic [3:0] LOCK_VAL = 4'(LOCK_N);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [3:0]       streak;
  step_t            step;
  logic             is_move;
  logic             step_dir;
  logic [3:0]       streak_inc;

  count_step_classifier #(.WIDTH(WIDTH)) u_classifier (
    .prev     (prev),
    .count_in (count_in),
    .step     (step)
  );

  assign is_move    = (step == STEP_UP) || (step == STEP_DOWN);
  assign step_dir   = (step == STEP_DOWN) ? MODE_DOWN : MODE_UP;
  assign streak_inc = (streak >= LOCK_VAL) ? LOCK_VAL : streak + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      streak     <= '0;
      locked     <= 1'b0;
      mode_out   <= MODE_UP;
      dir_change <= 1'b0;
      resync     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      dir_change <= 1'b0;
      resync     <= 1'b0;
      err        <= 1'b0;
      if (sample_en) begin
        prev <= count_in;
        case (state)
          IDLE: state <= ACQUIRE;
          ACQUIRE: begin
            if (is_move) begin
              if (step_dir == mode_out) begin
                streak <= streak_inc;
                if (streak_inc == LOCK_VAL) begin
                  locked <= 1'b1;
                  state  <= LOCKED;
                end
              end else begin
                mode_out <= step_dir;
                streak   <= 4'd1;
                if (LOCK_VAL == 4'd1) begin
                  locked <= 1'b1;
                  state  <= LOCKED;
                end
              end
            end else if (step == STEP_RESYNC) begin
              resync <= 1'b1;
              streak <= '0;
            end else if (step == STEP_JUMP) begin
              err    <= 1'b1;
              streak <= '0;
              if (err_count != '1) err_count <= err_count + 1'b1;
            end
          end
          LOCKED: begin
            if (is_move && step_dir != mode_out) begin
              dir_change <= 1'b1;
              locked     <= 1'b0;
              mode_out   <= step_dir;
              streak     <= 4'd1;
              state      <= ACQUIRE;
            end else if (step == STEP_RESYNC) begin
              resync <= 1'b1;
              locked <= 1'b0;
              streak <= '0;
              state  <= ACQUIRE;
            end else if (step == STEP_JUMP) begin
              err    <= 1'b1;
              locked <= 1'b0;
              streak <= '0;
              state  <= ACQUIRE;
              if (err_count != '1) err_count <= err_count + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
